fetch_execute_skid: RTL and testbench
=====================================

Name: fetch_execute_skid

Overview:
- Receiving end of the fetch-to-execute transfer in the two-stage pipeline.
- Captures pc/instr/npc produced by fetch and presents them, registered, to execute.
- Two-entry skid buffer with valid/ready handshake on both sides; execute can stall without a combinational ready path back into fetch.
- Flush from execute (taken branch/jump/exception) empties the buffer and forces a NOP bubble.

Parameters:
- WORD_W, 32, width of pc/instr/npc (matches word_t).
- NOP_INSTR, 32'h0000_0013, instruction presented to execute whenever no valid entry is held.

Ports:
- CLK  in  1  pipeline clock.
- nRST  in  1  asynchronous, active-high reset. The name is the codebase's, but polarity is high: 1 = reset asserted.
- fetch_valid  in  1  fetch offers an instruction this cycle.
- fetch_pc  in  WORD_W  pc of offered instruction.
- fetch_instr  in  WORD_W  offered instruction word.
- fetch_npc  in  WORD_W  predicted next pc.
- fetch_ready  out  1  buffer accepts this cycle; driven from a register.
- ex_valid  out  1  ex_* outputs hold a valid instruction.
- ex_pc  out  WORD_W  pc to execute.
- ex_instr  out  WORD_W  instruction to execute; NOP_INSTR when ex_valid=0.
- ex_npc  out  WORD_W  next pc to execute.
- ex_ready  in  1  execute consumes the head entry this cycle.
- flush  in  1  discard all held and incoming entries.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- Reset (nRST=1, async):
  - state=EMPTY, ex_valid=0, ex_pc=0, ex_npc=0, ex_instr=NOP_INSTR.
  - fetch_ready=1, occupancy=0, skid entry cleared.
- Handshakes:
  - Accept = fetch_valid & fetch_ready.
  - Consume = ex_valid & ex_ready.
  - Both evaluated on the same rising edge.
- Entries: a head entry (drives ex_*) and a skid entry. All outputs are registered.
- States (occupancy in parentheses):
  - EMPTY (0):
    - accept -> ONE, head<=fetch_*.
    - else stay.
    - ex_ready is ignored.
  - ONE (1):
    - accept & consume -> ONE, head<=fetch_*.
    - accept only -> FULL, skid<=fetch_*.
    - consume only -> EMPTY.
    - neither -> stay, head held stable.
  - FULL (2):
    - consume -> ONE, head<=skid.
    - else stay.
    - fetch_ready=0, so accept cannot occur.
- fetch_ready is registered and equals (next_state != FULL). It deasserts the cycle after FULL is entered and reasserts the cycle after leaving FULL.
- Latency: accept at edge N -> ex_valid=1 with that data after edge N (visible in cycle N+1) when EMPTY or consume-and-accept.
- Throughput: one instruction per cycle while ex_ready=1.
- Ordering: strict FIFO. The skid entry never overtakes the head.
- Empty buffer: ex_instr=NOP_INSTR. ex_pc/ex_npc hold their last values (don't-care for execute).
- Flush (synchronous, highest priority):
  - Next state EMPTY and ex_valid=0.
  - ex_instr=NOP_INSTR, skid cleared, fetch_ready=1 next cycle.
  - An accept in the flush cycle is discarded; a consume in the same cycle still counts for execute.
- Reset mid-operation: immediate return to reset values regardless of state; no entry survives.
- Stall stability: while ex_valid=1 and ex_ready=0, ex_* must not change (checked by assertion).

Decomposition:
- Add to tspp_types_pkg:
  - skid_state_t enum {EMPTY, ONE, FULL}.
  - fe_entry_t struct {word_t pc; word_t instr; word_t npc;}.
  - constant NOP_INSTR default.
- The top level is the port-level wrapper. It connects to fetch_execute_if: the fetch modport drives the fetch_* side; ex_* feeds execute.
- One sub-module, fe_entry_reg: a WORD_W*3 enable/clear register. It is instantiated twice (head and skid) so load/clear logic lives in one place.

Test Plan:
- Reset: assert nRST=1 mid-stream with occupancy=2 -> next sample ex_valid=0, ex_instr=0x00000013, ex_pc=0, fetch_ready=1, occupancy=0.
- Streaming: ex_ready=1; offer pc=0x200,0x204,0x208 on consecutive cycles -> ex_pc 0x200,0x204,0x208 on the following three cycles; fetch_ready stays 1.
- Stall fill: ex_ready=0; offer 0x300 then 0x304 -> occupancy=2, fetch_ready=0 the next cycle, ex_pc held at 0x300. Raise ex_ready -> 0x300 then 0x304 emerge in order, fetch_ready returns to 1.
- Flush when full: occupancy=2 with flush=1 and fetch_valid=1 (pc=0x400) -> next cycle ex_valid=0, ex_instr=0x00000013, occupancy=0, 0x400 never appears at ex_*.
- Simultaneous accept/consume in ONE: head=0x500, offer 0x504 with ex_ready=1 -> head=0x504, occupancy stays 1.
- Empty consume: ex_ready=1 with occupancy=0 -> no state change, ex_valid stays 0.

Source files
------------

// File: rtl/tspp_types_pkg.sv
// Shared types for the fetch/execute boundary of the two-stage pipeline.
package tspp_types_pkg;

  localparam int FE_WORD_W = 32;

  typedef logic [FE_WORD_W-1:0] word_t;

  // Canonical NOP (addi x0, x0, 0) shown to execute whenever nothing is held.
  localparam word_t DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Encoding doubles as the occupancy count, so occupancy is a plain register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    word_t npc;
  } fe_entry_t;

endpackage

// File: rtl/fetch_execute_if.sv
// Bundle of the fetch-to-execute transfer: fetch drives the fetch side,
// the skid buffer sits in the middle and execute consumes the ex side.
interface fetch_execute_if;
  import tspp_types_pkg::*;

  logic      fetch_valid;
  fe_entry_t fetch_entry;
  logic      fetch_ready;
  logic      ex_valid;
  fe_entry_t ex_entry;
  logic      ex_ready;

  modport fetch  (output fetch_valid, fetch_entry, input fetch_ready);
  modport buffer (input fetch_valid, fetch_entry, ex_ready,
                  output fetch_ready, ex_valid, ex_entry);
  modport ex     (input ex_valid, ex_entry, output ex_ready);

endinterface

// File: rtl/fe_entry_reg.sv
// One pc/instr/npc entry with load enable and synchronous clear; clear and
// reset both return the entry to RST_VAL.
module fe_entry_reg
  import tspp_types_pkg::*;
#(
  parameter fe_entry_t RST_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  fe_entry_t d,
  output fe_entry_t q
);

  // Entry storage: clear wins over load.
  // NOTE: entries are reset explicitly; the empty-buffer output must be a
  // known NOP, not whatever the flops power up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_execute_skid.sv
// Two-entry skid buffer between fetch and execute. Head entry drives ex_*,
// skid entry absorbs the one instruction fetch may send while execute stalls.
// fetch_ready comes from a flop, so there is no combinational ready path
// from execute back into fetch.
module fetch_execute_skid
  import tspp_types_pkg::*;
#(
  // Must match word_t; entries are stored as fe_entry_t.
  parameter int                WORD_W    = FE_WORD_W,
  parameter logic [WORD_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              CLK,
  input  logic              nRST,   // active-high asynchronous reset
  input  logic              fetch_valid,
  input  logic [WORD_W-1:0] fetch_pc,
  input  logic [WORD_W-1:0] fetch_instr,
  input  logic [WORD_W-1:0] fetch_npc,
  output logic              fetch_ready,
  output logic              ex_valid,
  output logic [WORD_W-1:0] ex_pc,
  output logic [WORD_W-1:0] ex_instr,
  output logic [WORD_W-1:0] ex_npc,
  input  logic              ex_ready,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  localparam fe_entry_t HEAD_RST = {{WORD_W{1'b0}}, NOP_INSTR, {WORD_W{1'b0}}};

  fetch_execute_if fe_if ();

  skid_state_t state, state_nxt;
  logic        valid_nxt;
  logic        accept, consume;
  logic        head_load, skid_load, skid_clear;
  fe_entry_t   head_d, head_q, skid_q;

  assign fe_if.fetch_valid = fetch_valid;
  assign fe_if.fetch_entry = '{pc: fetch_pc, instr: fetch_instr, npc: fetch_npc};
  assign fe_if.ex_ready    = ex_ready;
  assign fe_if.ex_entry    = head_q;

  assign accept  = fe_if.fetch_valid && fe_if.fetch_ready;
  assign consume = fe_if.ex_valid && fe_if.ex_ready;

  // Next state and entry moves; flush overrides every handshake.
  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    valid_nxt  = fe_if.ex_valid;
    head_load  = 1'b0;
    head_d     = fe_if.fetch_entry;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_nxt    = EMPTY;
      valid_nxt    = 1'b0;
      head_load    = 1'b1;
      head_d       = head_q;
      head_d.instr = NOP_INSTR;
      skid_clear   = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            valid_nxt = 1'b1;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_load = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            skid_load = 1'b1;
          end else if (consume) begin
            // pc/npc keep their last values; only the instruction becomes NOP.
            state_nxt    = EMPTY;
            valid_nxt    = 1'b0;
            head_load    = 1'b1;
            head_d       = head_q;
            head_d.instr = NOP_INSTR;
          end
        end
        FULL: begin
          if (consume) begin
            state_nxt = ONE;
            head_load = 1'b1;
            head_d    = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, valid and registered ready.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state             <= EMPTY;
      fe_if.ex_valid    <= 1'b0;
      fe_if.fetch_ready <= 1'b1;
    end else begin
      state             <= state_nxt;
      fe_if.ex_valid    <= valid_nxt;
      fe_if.fetch_ready <= (state_nxt != FULL);
    end
  end

  fe_entry_reg #(.RST_VAL(HEAD_RST)) u_head (
    .clk   (CLK),
    .rst   (nRST),
    .load  (head_load),
    .clear (1'b0),
    .d     (head_d),
    .q     (head_q)
  );

  fe_entry_reg #(.RST_VAL('0)) u_skid (
    .clk   (CLK),
    .rst   (nRST),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (fe_if.fetch_entry),
    .q     (skid_q)
  );

  assign fetch_ready = fe_if.fetch_ready;
  assign ex_valid    = fe_if.ex_valid;
  assign ex_pc       = fe_if.ex_entry.pc;
  assign ex_instr    = fe_if.ex_entry.instr;
  assign ex_npc      = fe_if.ex_entry.npc;
  assign occupancy   = state;

endmodule

// File: tb/tb_fetch_execute_skid.sv
// Scoreboard bench for fetch_execute_skid: the stimulus side keeps a model
// FIFO of capacity two and pushes each accepted instruction; the monitor
// compares ex_* with the oldest expected entry each cycle and pops on consume.
module tb_fetch_execute_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_instr, fetch_npc;
  logic        fetch_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_npc;
  logic        ex_ready;
  logic        flush;
  logic [1:0]  occupancy;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  ent_t sb[$];
  int   occ = 0;
  int   checks = 0;
  int   errors = 0;

  fetch_execute_skid dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_npc   (fetch_npc),
    .fetch_ready (fetch_ready),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_instr    (ex_instr),
    .ex_npc      (ex_npc),
    .ex_ready    (ex_ready),
    .flush       (flush),
    .occupancy   (occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Head entry must stay frozen while execute stalls.
  property p_stall_stable;
    @(posedge CLK) disable iff (nRST)
      (ex_valid && !ex_ready && !flush) |=>
        (ex_valid && $stable(ex_pc) && $stable(ex_instr) && $stable(ex_npc));
  endproperty
  a_stall_stable: assert property (p_stall_stable)
    else $error("FAIL stall_stable: ex_* changed while stalled at %0t", $time);

  // Monitor: inputs are stable at the falling edge and outputs reflect the
  // last rising edge, so the handshake seen here is the one about to happen.
  always @(negedge CLK) begin
    if (!nRST) begin
      check("fetch_ready", {31'b0, fetch_ready}, {31'b0, occ < 2});
      check("occupancy", {30'b0, occupancy}, occ);
      check("ex_valid", {31'b0, ex_valid}, {31'b0, occ > 0});
      if (occ == 0) begin
        check("ex_instr_nop", ex_instr, NOP);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: DUT holds %0d entries, none expected at %0t", occ, $time);
      end else begin
        check("ex_pc", ex_pc, sb[0].pc);
        check("ex_instr", ex_instr, sb[0].instr);
        check("ex_npc", ex_npc, sb[0].npc);
        if (ex_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus, entered and left at rising edge + 1.
  task automatic cycle(input logic fv, input logic [31:0] pc, input logic er, input logic fl);
    ent_t e;
    bit   acc, con;
    e.pc        = pc;
    e.instr     = $urandom;
    e.npc       = pc + 32'd4;
    fetch_valid = fv;
    fetch_pc    = e.pc;
    fetch_instr = e.instr;
    fetch_npc   = e.npc;
    ex_ready    = er;
    flush       = fl;
    @(posedge CLK);
    acc = fv && (occ < 2);
    con = er && (occ > 0);
    if (fl) begin
      occ = 0;
      sb.delete();
    end else begin
      occ = occ - int'(con) + int'(acc);
      if (acc) sb.push_back(e);
    end
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ex_valid"}, {31'b0, ex_valid}, 32'd0);
    check({tag, "_ex_instr"}, ex_instr, NOP);
    check({tag, "_ex_pc"}, ex_pc, 32'd0);
    check({tag, "_ex_npc"}, ex_npc, 32'd0);
    check({tag, "_fetch_ready"}, {31'b0, fetch_ready}, 32'd1);
    check({tag, "_occupancy"}, {30'b0, occupancy}, 32'd0);
  endtask

  initial begin
    nRST        = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    fetch_instr = '0;
    fetch_npc   = '0;
    ex_ready    = 1'b0;
    flush       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset_checks("reset");
    nRST = 1'b0;

    // Consume request on an empty buffer changes nothing.
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-to-back streaming with execute always ready.
    cycle(1'b1, 32'h200, 1'b1, 1'b0);
    cycle(1'b1, 32'h204, 1'b1, 1'b0);
    cycle(1'b1, 32'h208, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Stall fill, hold, then drain in order.
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 32'h3F0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a simultaneous offer that must be dropped.
    cycle(1'b1, 32'h600, 1'b0, 1'b0);
    cycle(1'b1, 32'h604, 1'b0, 1'b0);
    cycle(1'b1, 32'h400, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Accept and consume together while holding one entry.
    cycle(1'b1, 32'h500, 1'b0, 1'b0);
    cycle(1'b1, 32'h504, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0,
            {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while full.
    cycle(1'b1, 32'h700, 1'b0, 1'b0);
    cycle(1'b1, 32'h704, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("full_before_reset", {30'b0, occupancy}, 32'd2);
    #2;
    nRST = 1'b1;
    #1;
    reset_checks("midreset");
    occ = 0;
    sb.delete();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h800, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
